// File: rtl/mips_multicycle_ctrl.sv
// Multicycle main controller for the MIPS datapath with IR/A/B/ALUOut/MDR
// holding registers and one shared memory port.
//
// Ports:
//   clk, rst       rising-edge clock, asynchronous active-high reset
//   opcode         IR[31:26], valid from DECODE onward
//   zero           ALU zero flag (qualifies pc_en in BEQ)
//   mem_ready      memory completes the current access this cycle
//   IorD .. RegWrite  datapath control strobes, decoded from the state
//   state          current state code (debug)
//   halted         high while in HALT
//   illegal_op     one-cycle pulse in DECODE on an unknown opcode
//   instr_count    retired-instruction counter, wraps modulo 2^CNT_W
module mips_multicycle_ctrl #(
    parameter int unsigned CNT_W  = 32,
    parameter logic [5:0]  HLT_OP = 6'b111111
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             pc_en,
    output logic [1:0]       PCSource,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic             addi,
    output logic             RegDst,
    output logic             MemtoReg,
    output logic             RegWrite,
    output logic [3:0]       state,
    output logic             halted,
    output logic             illegal_op,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [3:0] {
        S_RESET  = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_REXEC  = 4'd7,
        S_RWB    = 4'd8,
        S_BEQ    = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11,
        S_JUMP   = 4'd12,
        S_HALT   = 4'd13
    } state_t;

    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    state_t st_q, st_d;
    logic   retire;

    // Next state; retire marks the final cycle of a completed instruction.
    always_comb begin
        st_d   = S_RESET;
        retire = 1'b0;
        case (st_q)
            S_RESET:  st_d = S_FETCH;
            S_FETCH:  st_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: st_d = S_MEMADR;
                    OP_R:         st_d = S_REXEC;
                    OP_BEQ:       st_d = S_BEQ;
                    OP_ADDI:      st_d = S_ADDIEX;
                    OP_J:         st_d = S_JUMP;
                    HLT_OP:       st_d = S_HALT;
                    default:      st_d = S_FETCH;
                endcase
            end
            S_MEMADR: st_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  st_d = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWB:  begin st_d = S_FETCH; retire = 1'b1; end
            S_MEMWR:  begin
                st_d   = mem_ready ? S_FETCH : S_MEMWR;
                retire = mem_ready;
            end
            S_REXEC:  st_d = S_RWB;
            S_RWB:    begin st_d = S_FETCH; retire = 1'b1; end
            S_BEQ:    begin st_d = S_FETCH; retire = 1'b1; end
            S_ADDIEX: st_d = S_ADDIWB;
            S_ADDIWB: begin st_d = S_FETCH; retire = 1'b1; end
            S_JUMP:   begin st_d = S_FETCH; retire = 1'b1; end
            S_HALT:   st_d = S_HALT;
            default:  st_d = S_RESET;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q        <= S_RESET;
            instr_count <= '0;
        end else begin
            st_q <= st_d;
            if (retire)
                instr_count <= instr_count + CNT_W'(1);
        end
    end

    // Moore decode of the state register; reset forces S_RESET and hence
    // drops every strobe without waiting for a clock edge.
    always_comb begin
        IorD       = 1'b0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        pc_en      = 1'b0;
        PCSource   = 2'b00;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        ALUOp      = 2'b00;
        addi       = 1'b0;
        RegDst     = 1'b0;
        MemtoReg   = 1'b0;
        RegWrite   = 1'b0;
        halted     = 1'b0;
        illegal_op = 1'b0;
        case (st_q)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                IRWrite = mem_ready;
                pc_en   = mem_ready;
            end
            S_DECODE: begin
                ALUSrcB    = 2'b11;
                illegal_op = (st_d == S_FETCH);
            end
            S_MEMADR: begin ALUSrcA = 1'b1; ALUSrcB = 2'b10; end
            S_MEMRD:  begin MemRead = 1'b1; IorD = 1'b1; end
            S_MEMWB:  begin RegWrite = 1'b1; MemtoReg = 1'b1; end
            S_MEMWR:  begin MemWrite = 1'b1; IorD = 1'b1; end
            S_REXEC:  begin ALUSrcA = 1'b1; ALUOp = 2'b10; end
            S_RWB:    begin RegWrite = 1'b1; RegDst = 1'b1; end
            S_BEQ: begin
                ALUSrcA  = 1'b1;
                ALUOp    = 2'b01;
                PCSource = 2'b01;
                pc_en    = zero;
            end
            S_ADDIEX: begin ALUSrcA = 1'b1; ALUSrcB = 2'b10; addi = 1'b1; end
            S_ADDIWB: RegWrite = 1'b1;
            S_JUMP:   begin PCSource = 2'b10; pc_en = 1'b1; end
            S_HALT:   halted = 1'b1;
            default:  ;
        endcase
    end

    assign state = st_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
module tb_mips_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  opcode;
    logic        zero;
    logic        mem_ready;
    logic        IorD, MemRead, MemWrite, IRWrite, pc_en;
    logic [1:0]  PCSource, ALUSrcB, ALUOp;
    logic        ALUSrcA, addi, RegDst, MemtoReg, RegWrite;
    logic [3:0]  state;
    logic        halted, illegal_op;
    logic [31:0] instr_count;

    // Narrow-counter copy used to observe wraparound.
    logic        n_IorD, n_MemRead, n_MemWrite, n_IRWrite, n_pc_en;
    logic [1:0]  n_PCSource, n_ALUSrcB, n_ALUOp;
    logic        n_ALUSrcA, n_addi, n_RegDst, n_MemtoReg, n_RegWrite;
    logic [3:0]  n_state;
    logic        n_halted, n_illegal_op;
    logic [2:0]  n_instr_count;

    int compared   = 0;
    int mismatched = 0;
    int cnt        = 0;

    always #5 clk = ~clk;

    mips_multicycle_ctrl #(.CNT_W(32), .HLT_OP(6'b111111)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .pc_en(pc_en), .PCSource(PCSource), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ALUOp(ALUOp), .addi(addi), .RegDst(RegDst), .MemtoReg(MemtoReg),
        .RegWrite(RegWrite), .state(state), .halted(halted),
        .illegal_op(illegal_op), .instr_count(instr_count)
    );

    mips_multicycle_ctrl #(.CNT_W(3), .HLT_OP(6'b111111)) dut_n (
        .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .IorD(n_IorD), .MemRead(n_MemRead), .MemWrite(n_MemWrite), .IRWrite(n_IRWrite),
        .pc_en(n_pc_en), .PCSource(n_PCSource), .ALUSrcA(n_ALUSrcA), .ALUSrcB(n_ALUSrcB),
        .ALUOp(n_ALUOp), .addi(n_addi), .RegDst(n_RegDst), .MemtoReg(n_MemtoReg),
        .RegWrite(n_RegWrite), .state(n_state), .halted(n_halted),
        .illegal_op(n_illegal_op), .instr_count(n_instr_count)
    );

    logic [17:0] ctrl;
    assign ctrl = {IorD, MemRead, MemWrite, IRWrite, pc_en, PCSource, ALUSrcA,
                   ALUSrcB, ALUOp, addi, RegDst, MemtoReg, RegWrite, halted, illegal_op};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit is_legal(input logic [5:0] op);
        return op inside {6'b100011, 6'b101011, 6'b000000, 6'b000100,
                          6'b001000, 6'b000010, 6'b111111};
    endfunction

    // Control word each phase of an instruction must present.
    function automatic logic [17:0] exp_ctrl(input int st, input bit mr, input bit z,
                                             input logic [5:0] op);
        logic iord = 0, mrd = 0, mwr = 0, irw = 0, pce = 0, srca = 0, ad = 0;
        logic rdst = 0, m2r = 0, rw = 0, hl = 0, ill = 0;
        logic [1:0] pcs = 0, srcb = 0, aop = 0;
        case (st)
            1:  begin mrd = 1; srcb = 2'b01; irw = mr; pce = mr; end
            2:  begin srcb = 2'b11; ill = !is_legal(op); end
            3:  begin srca = 1; srcb = 2'b10; end
            4:  begin mrd = 1; iord = 1; end
            5:  begin rw = 1; m2r = 1; end
            6:  begin mwr = 1; iord = 1; end
            7:  begin srca = 1; aop = 2'b10; end
            8:  begin rw = 1; rdst = 1; end
            9:  begin srca = 1; aop = 2'b01; pcs = 2'b01; pce = z; end
            10: begin srca = 1; srcb = 2'b10; ad = 1; end
            11: rw = 1;
            12: begin pcs = 2'b10; pce = 1; end
            13: hl = 1;
            default: ;
        endcase
        return {iord, mrd, mwr, irw, pce, pcs, srca, srcb, aop, ad, rdst, m2r, rw, hl, ill};
    endfunction

    task automatic check_all(input int st, input bit mr, input bit z, input logic [5:0] op);
        chk("state", 32'(state), 32'(st));
        chk("ctrl", 32'(ctrl), 32'(exp_ctrl(st, mr, z, op)));
        chk("instr_count", instr_count, 32'(cnt));
        chk("instr_count_wrap", 32'(n_instr_count), 32'(cnt % 8));
    endtask

    // Runs one instruction from FETCH: fw fetch waits, mw data waits.
    // With abort set, reset is asserted mid-cycle in the first MEMWR wait.
    task automatic run_instr(input logic [5:0] op, input int fw, input int mw,
                             input bit z, input bit abort);
        int  sq[$];
        bit  mq[$];
        bit  retires;
        repeat (fw) begin sq.push_back(1); mq.push_back(0); end
        sq.push_back(1); mq.push_back(1);
        sq.push_back(2); mq.push_back(1'($urandom));
        case (op)
            6'b100011: begin
                sq.push_back(3); mq.push_back(1'($urandom));
                repeat (mw) begin sq.push_back(4); mq.push_back(0); end
                sq.push_back(4); mq.push_back(1);
                sq.push_back(5); mq.push_back(1'($urandom));
            end
            6'b101011: begin
                sq.push_back(3); mq.push_back(1'($urandom));
                repeat (mw) begin sq.push_back(6); mq.push_back(0); end
                sq.push_back(6); mq.push_back(1);
            end
            6'b000000: begin
                sq.push_back(7); mq.push_back(1'($urandom));
                sq.push_back(8); mq.push_back(1'($urandom));
            end
            6'b000100: begin sq.push_back(9); mq.push_back(1'($urandom)); end
            6'b001000: begin
                sq.push_back(10); mq.push_back(1'($urandom));
                sq.push_back(11); mq.push_back(1'($urandom));
            end
            6'b000010: begin sq.push_back(12); mq.push_back(1'($urandom)); end
            6'b111111: begin sq.push_back(13); mq.push_back(1'($urandom)); end
            default: ;
        endcase
        retires = is_legal(op) && op != 6'b111111;
        foreach (sq[i]) begin
            @(negedge clk);
            mem_ready = mq[i];
            zero      = (sq[i] == 9) ? z : 1'($urandom);
            opcode    = (sq[i] == 1) ? 6'($urandom) : op;
            #1;
            check_all(sq[i], mq[i], zero, op);
            if (abort && sq[i] == 6 && !mq[i]) begin
                #2 rst = 1'b1;
                #1;
                chk("abort_state", 32'(state), 32'd0);
                chk("abort_ctrl", 32'(ctrl), 32'd0);
                chk("abort_count", instr_count, 32'd0);
                cnt = 0;
                @(negedge clk);
                rst = 1'b0;
                return;
            end
        end
        if (retires) cnt++;
    endtask

    initial begin
        logic [5:0] rop;
        rst = 1'b1; opcode = '0; zero = 1'b0; mem_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_state", 32'(state), 32'd0);
        chk("reset_ctrl", 32'(ctrl), 32'd0);
        chk("reset_count", instr_count, 32'd0);
        rst = 1'b0;

        run_instr(6'b100011, 0, 0, 0, 0);   // lw, no waits
        run_instr(6'b101011, 0, 3, 0, 0);   // sw, MEMWR held 4 cycles
        run_instr(6'b000100, 0, 0, 1, 0);   // beq taken
        run_instr(6'b000100, 1, 0, 0, 0);   // beq not taken, fetch wait
        run_instr(6'b010101, 0, 0, 0, 0);   // illegal
        run_instr(6'b000000, 0, 0, 0, 0);
        run_instr(6'b001000, 2, 0, 0, 0);
        run_instr(6'b000010, 0, 0, 0, 0);
        run_instr(6'b100011, 1, 2, 0, 0);

        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(6))
                0: rop = 6'b100011;
                1: rop = 6'b101011;
                2: rop = 6'b000000;
                3: rop = 6'b000100;
                4: rop = 6'b001000;
                5: rop = 6'b000010;
                default: begin
                    rop = 6'b010101;
                    for (int t = 0; t < 50; t++) begin
                        rop = 6'($urandom);
                        if (!is_legal(rop)) break;
                    end
                    if (is_legal(rop)) rop = 6'b110011;
                end
            endcase
            run_instr(rop, $urandom_range(2), $urandom_range(2), 1'($urandom), 0);
        end

        run_instr(6'b101011, 0, 2, 0, 1);   // reset mid-MEMWR
        run_instr(6'b100011, 0, 0, 0, 0);

        run_instr(6'b111111, 0, 0, 0, 0);   // halt
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            mem_ready = 1'(c);
            zero      = 1'($urandom);
            opcode    = 6'($urandom);
            #1;
            check_all(13, mem_ready, zero, opcode);
        end
        rst = 1'b1;
        #1;
        chk("halt_reset_state", 32'(state), 32'd0);
        cnt = 0;
        @(negedge clk);
        rst = 1'b0;
        run_instr(6'b000000, 0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
